// File: rtl/hex_disp_arbiter.sv
// hex_disp_arbiter: round-robin arbiter that gives one of three sources the eight-digit hex display
// for exactly HOLD cycles per grant, with registered leading-zero blanking.
module hex_disp_arbiter #(
    parameter int          HOLD       = 4,
    parameter logic [31:0] IDLE_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic [2:0]  gnt,
    output logic [1:0]  owner,
    output logic        disp_valid,
    output logic [31:0] disp_data,
    output logic [7:0]  blank
);
    typedef enum logic {IDLE, HOLDING} state_t;

    localparam logic [15:0] RELOAD = 16'(HOLD - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [1:0]  ptr, ptr_n, owner_n, win, p1, p2;
    logic [2:0]  gnt_n;
    logic        valid_n, grant, release_n;
    logic [31:0] data_n;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return p == 2'd2 ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [31:0] sel(input logic [1:0] i);
        return i == 2'd0 ? data0 : i == 2'd1 ? data1 : data2;
    endfunction

    // digit k is dark when it and every more significant digit are zero; digit 0 always lit
    function automatic logic [7:0] blank_of(input logic [31:0] d);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 1; k < 8; k++) b[k] = (d >> (4 * k)) == 32'd0;
        return b;
    endfunction

    always_comb begin
        p1  = inc3(ptr);
        p2  = inc3(p1);
        win = req[p1] ? p1 : req[p2] ? p2 : ptr;
    end

    // ptr always equals the current owner while holding, so the winner is the owner only when it alone requests
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ptr_n     = ptr;
        gnt_n     = gnt;
        owner_n   = owner;
        valid_n   = disp_valid;
        data_n    = disp_data;
        grant     = (state == IDLE || cnt == 16'd0) && req != 3'b000;
        release_n = state == HOLDING && cnt == 16'd0 && req == 3'b000;
        if (grant) begin
            state_n = HOLDING;
            cnt_n   = RELOAD;
            ptr_n   = win;
            gnt_n   = 3'b001 << win;
            owner_n = win;
            valid_n = 1'b1;
            data_n  = sel(win);
        end else if (release_n) begin
            state_n = IDLE;
            cnt_n   = 16'd0;
            gnt_n   = 3'b000;
            owner_n = 2'd3;
            valid_n = 1'b0;
            data_n  = IDLE_VALUE;
        end else if (state == HOLDING) begin
            cnt_n  = cnt - 16'd1;
            data_n = (gnt & req) != 3'b000 ? sel(owner) : disp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 16'd0;
            ptr        <= 2'd2;
            gnt        <= 3'b000;
            owner      <= 2'd3;
            disp_valid <= 1'b0;
            disp_data  <= IDLE_VALUE;
            blank      <= blank_of(IDLE_VALUE);
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            gnt        <= gnt_n;
            owner      <= owner_n;
            disp_valid <= valid_n;
            disp_data  <= data_n;
            blank      <= blank_of(data_n);
        end
    end
endmodule

// File: tb/tb_hex_disp_arbiter.sv
// tb_hex_disp_arbiter: directed checks of the hex display arbiter (HOLD=4 main instance, HOLD=1 second instance).
module tb_hex_disp_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [31:0] data0 = 32'h0, data1 = 32'h0, data2 = 32'h0;
    logic [2:0]  gnt, gnt1;
    logic [1:0]  owner, owner1;
    logic        disp_valid, disp_valid1;
    logic [31:0] disp_data, disp_data1;
    logic [7:0]  blank, blank1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hex_disp_arbiter #(.HOLD(4), .IDLE_VALUE(32'h0000_0000)) u_dut (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .data2(data2),
        .gnt(gnt), .owner(owner), .disp_valid(disp_valid), .disp_data(disp_data), .blank(blank)
    );

    hex_disp_arbiter #(.HOLD(1), .IDLE_VALUE(32'h0000_0000)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .data2(data2),
        .gnt(gnt1), .owner(owner1), .disp_valid(disp_valid1), .disp_data(disp_data1), .blank(blank1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt, owner, disp_valid} !== {3'b000, 2'd3, 1'b0}) begin
            failures++;
            $display("FAIL reset_ctrl: got gnt=%b owner=%0d valid=%b, want 000/3/0", gnt, owner, disp_valid);
        end
        checks++;
        if ({disp_data, blank} !== {32'h0, 8'hFE}) begin
            failures++;
            $display("FAIL reset_data: got data=%h blank=%h, want 00000000/fe", disp_data, blank);
        end
        data0 = 32'h1111_1111;
        step();
        step();
        checks++;
        if ({gnt, owner, disp_valid, disp_data, blank} !== {3'b000, 2'd3, 1'b0, 32'h0, 8'hFE}) begin
            failures++;
            $display("FAIL idle_hold: got gnt=%b owner=%0d valid=%b data=%h blank=%h", gnt, owner, disp_valid, disp_data, blank);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 3'b010;
        data1 = 32'h0000_1234;
        step();
        checks++;
        if ({gnt, owner, disp_valid, disp_data, blank} !== {3'b010, 2'd1, 1'b1, 32'h0000_1234, 8'hF0}) begin
            failures++;
            $display("FAIL single_first: got gnt=%b owner=%0d valid=%b data=%h blank=%h, want 010/1/1/00001234/f0",
                     gnt, owner, disp_valid, disp_data, blank);
        end
        data1 = 32'h00AB_CDEF;
        data0 = 32'hFFFF_FFFF;
        for (int c = 2; c <= 10; c++) begin
            step();
            checks++;
            if ({gnt, disp_valid, disp_data, blank} !== {3'b010, 1'b1, 32'h00AB_CDEF, 8'hC0}) begin
                failures++;
                $display("FAIL single_hold c%0d: got gnt=%b valid=%b data=%h blank=%h, want 010/1/00abcdef/c0",
                         c, gnt, disp_valid, disp_data, blank);
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0] e;
        logic [31:0] ed;
        do_reset();
        data0 = 32'h0000_000A;
        data1 = 32'h0000_00B0;
        data2 = 32'h0000_0C00;
        req = 3'b111;
        for (int c = 1; c <= 13; c++) begin
            step();
            e = 2'((c - 1) / 4 % 3);
            ed = e == 2'd0 ? 32'h0000_000A : e == 2'd1 ? 32'h0000_00B0 : 32'h0000_0C00;
            checks++;
            if ({gnt, owner, disp_data} !== {3'b001 << e, e, ed}) begin
                failures++;
                $display("FAIL contention c%0d: got gnt=%b owner=%0d data=%h, want owner %0d data=%h",
                         c, gnt, owner, disp_data, e, ed);
            end
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        req = 3'b001;
        data0 = 32'hAAAA_0005;
        step();
        checks++;
        if ({gnt, disp_data, blank} !== {3'b001, 32'hAAAA_0005, 8'h00}) begin
            failures++;
            $display("FAIL drop_first: got gnt=%b data=%h blank=%h, want 001/aaaa0005/00", gnt, disp_data, blank);
        end
        req = 3'b000;
        data0 = 32'h0;
        for (int c = 2; c <= 4; c++) begin
            step();
            checks++;
            if ({gnt, disp_valid, disp_data} !== {3'b001, 1'b1, 32'hAAAA_0005}) begin
                failures++;
                $display("FAIL drop_freeze c%0d: got gnt=%b valid=%b data=%h, want 001/1/aaaa0005", c, gnt, disp_valid, disp_data);
            end
        end
        step();
        checks++;
        if ({gnt, owner, disp_valid, disp_data, blank} !== {3'b000, 2'd3, 1'b0, 32'h0, 8'hFE}) begin
            failures++;
            $display("FAIL drop_idle: got gnt=%b owner=%0d valid=%b data=%h blank=%h, want 000/3/0/00000000/fe",
                     gnt, owner, disp_valid, disp_data, blank);
        end
    endtask

    task automatic test_handoff();
        do_reset();
        data0 = 32'h0000_0001;
        data2 = 32'h0000_0002;
        req = 3'b001;
        step();
        step();
        step();
        step();
        req = 3'b100;
        step();
        checks++;
        if ({gnt, owner, disp_valid, disp_data} !== {3'b100, 2'd2, 1'b1, 32'h0000_0002}) begin
            failures++;
            $display("FAIL handoff: got gnt=%b owner=%0d valid=%b data=%h, want 100/2/1/00000002",
                     gnt, owner, disp_valid, disp_data);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        data0 = 32'h0000_0050;
        data1 = 32'h0000_0060;
        req = 3'b010;
        step();
        step();
        rst = 1'b1;
        req = 3'b111;
        step();
        checks++;
        if ({gnt, owner, disp_valid, disp_data} !== {3'b000, 2'd3, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL midreset_idle: got gnt=%b owner=%0d valid=%b data=%h, want 000/3/0/00000000",
                     gnt, owner, disp_valid, disp_data);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({gnt, owner, disp_data} !== {3'b001, 2'd0, 32'h0000_0050}) begin
            failures++;
            $display("FAIL midreset_restart: got gnt=%b owner=%0d data=%h, want 001/0/00000050", gnt, owner, disp_data);
        end
    endtask

    task automatic test_hold1();
        logic [2:0] e;
        do_reset();
        req = 3'b011;
        for (int c = 1; c <= 6; c++) begin
            step();
            e = (c % 2 == 1) ? 3'b001 : 3'b010;
            checks++;
            if ({gnt1, disp_valid1} !== {e, 1'b1}) begin
                failures++;
                $display("FAIL hold1 c%0d: got gnt=%b valid=%b, want %b/1", c, gnt1, disp_valid1, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_early_drop();
        test_handoff();
        test_mid_reset();
        test_hold1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hex_disp_arbiter.md
HEX_DISP_ARBITER -- requirements
Module: hex_disp_arbiter

Interface
REQ-001 SHALL have parameter HOLD, default 4, the exact number of cycles a granted source owns the display per grant; legal range 1..65535.
REQ-002 SHALL have parameter IDLE_VALUE, default 32'h0000_0000, the value presented when no source owns the display.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req  input  3  per-source display request, bit i for source i.
REQ-006 SHALL have ports data0, data1, data2  input  32 each  the eight-nibble value of source 0/1/2, nibble k giving hex digit k.
REQ-007 SHALL have port gnt  output  3  registered one-hot grant, or 3'b000 when idle.
REQ-008 SHALL have port owner  output  2  registered index of the granted source, or 2'd3 when idle.
REQ-009 SHALL have port disp_valid  output  1  registered; 1 while any source owns the display.
REQ-010 SHALL have port disp_data  output  32  registered value driving the eight-digit hex display's 32-bit input.
REQ-011 SHALL have port blank  output  8  registered leading-zero blank mask for the digits; bit k=1 means digit k is dark.

Function
REQ-012 SHALL implement two states: IDLE (no owner) and HOLD (one owner, hold counter running).
REQ-013 In IDLE with req==0, all outputs SHALL hold their idle values.
REQ-014 In IDLE with req!=0 at edge t, the block SHALL, at edge t+1:
  - grant the winner per REQ-017 (gnt one-hot, owner=index, disp_valid=1);
  - load disp_data with the winner's data as sampled at t;
  - load the hold counter with HOLD-1;
  - enter HOLD.
REQ-015 In HOLD with counter!=0, the counter SHALL decrement by 1 per cycle. disp_data SHALL load data[owner] when req[owner]=1 and SHALL freeze at its last value when req[owner]=0. The owner is not released early.
REQ-016 In HOLD with counter==0, the block SHALL arbitrate on the current req and apply the result at the next edge:
  - other source(s) requesting: hand off directly to the REQ-017 winner (new gnt, owner, disp_data, counter=HOLD-1), without passing through IDLE;
  - only the owner requesting: keep the owner and reload the counter with HOLD-1;
  - req==0: enter IDLE.
REQ-017 Arbitration SHALL be round-robin with pointer = last granted index. Search order is ptr+1, ptr+2, ptr (mod 3). The pointer is 2 after reset, so source 0 wins first.
REQ-018 Entering IDLE SHALL set gnt=000, owner=3, disp_valid=0, disp_data=IDLE_VALUE.
REQ-019 Each owner SHALL hold the display for exactly HOLD consecutive cycles per grant. With HOLD=1, arbitration occurs every cycle.
REQ-020 blank SHALL always correspond to the current disp_data: bit k (k=1..7) =1 iff nibbles k..7 are all zero; bit 0 is always 0. It is registered in the same edge as disp_data.
REQ-021 gnt SHALL never have more than one bit set, and owner, gnt and disp_valid SHALL always be mutually consistent.
REQ-022 Changes on data of non-owner sources SHALL never affect disp_data.

Reset
REQ-023 rst=1 sampled at an edge SHALL, at that edge, force:
  - state IDLE, counter 0, pointer 2;
  - gnt=000, owner=3, disp_valid=0;
  - disp_data=IDLE_VALUE, blank=8'hFE for the default IDLE_VALUE.
REQ-024 Reset asserted mid-HOLD SHALL abandon the grant immediately with no further handoff. Arbitration after reset release SHALL restart from pointer 2.

Verification
REQ-025 Single requester (HOLD=4): req=010, data1=32'h0000_1234 from cycle 0:
  - cycle 1: gnt=010, disp_data=32'h0000_1234, blank=8'hF0;
  - gnt stays 010 continuously via reload.
REQ-026 Contention (HOLD=4): req=111 from cycle 0. Grants SHALL be source 0 for cycles 1-4, source 1 for 5-8, source 2 for 9-12, source 0 again at 13.
REQ-027 Early drop (HOLD=4): source 0 granted at cycle 1 with data0=32'hAAAA_0005; req0 drops at cycle 2 while data0 changes to 32'h0.
  - disp_data SHALL stay 32'hAAAA_0005 through cycle 4;
  - cycle 5: IDLE, disp_data=0, blank=8'hFE.
REQ-028 Handoff vs. idle (HOLD=4): req=001 then req=100 asserted at the owner's counter==0 cycle. Next cycle SHALL show gnt=100, disp_valid=1, with no idle cycle in between.
REQ-029 Mid-operation reset: rst=1 for one cycle during source 1's HOLD.
  - next cycle: gnt=000, owner=3, disp_data=IDLE_VALUE;
  - with req=111 afterward, source 0 wins first.
REQ-030 HOLD=1, req=011: grant SHALL alternate 0,1,0,1 every cycle.
